dmem_ctrl: RTL and testbench

- Sequences every core load/store onto the single-port data-memory bus.
- Latches the request, checks alignment, builds byte lanes and replicated write data, and runs the bus request/grant/response handshake.
- Aligns and extends read data, then reports completion or error back to the core's memory stage.
- Sits between the core's memory stage and the data-memory interconnect; the core stalls while a request is in flight.

---
 rtl/dmem_pkg.sv | 41 ++++
 rtl/load_aligner.sv | 24 ++
 rtl/dmem_ctrl.sv | 148 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: FSM states,
// access sizes, RISC-V load/store funct3 codes and request legality checks.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10} size_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Size 2'b11 is never legal; stores have no unsigned variants.
   function automatic logic is_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] offset);
      logic bad_store;
      bad_store = we & !(funct3 inside {SB, SH, SW});
      case (funct3[1:0])
         SZ_B:    is_illegal = bad_store;
         SZ_H:    is_illegal = bad_store | offset[0];
         SZ_W:    is_illegal = bad_store | (offset != 2'b00);
         default: is_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] offset);
      case (size)
         SZ_B:    lane_mask = 4'b0001 << offset;
         SZ_H:    lane_mask = 4'b0011 << offset;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Combinational read-data alignment: picks the addressed byte/half out of the
// bus word and sign- or zero-extends it to 32 bits.
module load_aligner
   import dmem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         LB, LBU: result = {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
         LH, LHU: result = {{16{~funct3[2] & shifted[15]}}, shifted[15:0]};
         LW:      result = rdata;
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Core memory-stage to data-memory bus sequencer: accepts one load/store at a
// time, drives the req/gnt/rvalid handshake and returns done/err/read data.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_valid,
   input  logic        core_we,
   input  logic [2:0]  core_funct3,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wd,
   output logic        core_ready,
   output logic        core_done,
   output logic        core_err,
   output logic [31:0] core_rd,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_reg;
   logic             we_reg;
   logic [2:0]       funct3_reg;
   logic [1:0]       offset_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [1:0]  req_size;
   logic        req_illegal;
   logic [3:0]  req_be;
   logic [31:0] lane_wdata;
   logic [31:0] aligned_rd;

   assign req_size    = core_funct3[1:0];
   assign req_illegal = is_illegal(core_we, core_funct3, core_addr[1:0]);
   assign req_be      = lane_mask(req_size, core_addr[1:0]);
   assign core_ready  = (state_reg == IDLE);

   // Each byte lane carries the store byte/half that would land there.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_wdata[8*gi +: 8] = (req_size == SZ_B) ? core_wd[7:0] :
                                     (req_size == SZ_H) ? core_wd[8*(gi%2) +: 8] :
                                                          core_wd[8*gi +: 8];
   end

   load_aligner u_load_aligner (
      .rdata  (bus_rdata),
      .offset (offset_reg),
      .funct3 (funct3_reg),
      .result (aligned_rd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         we_reg     <= 1'b0;
         funct3_reg <= 3'b000;
         offset_reg <= 2'b00;
         cnt_reg    <= '0;
         core_done  <= 1'b0;
         core_err   <= 1'b0;
         core_rd    <= '0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_be     <= '0;
         bus_wdata  <= '0;
      end else begin
         core_done <= 1'b0;
         core_err  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (core_valid) begin
                  we_reg     <= core_we;
                  funct3_reg <= core_funct3;
                  offset_reg <= core_addr[1:0];
                  if (req_illegal) begin
                     state_reg <= DONE;
                     core_done <= 1'b1;
                     core_err  <= 1'b1;
                  end else begin
                     state_reg <= REQ;
                     cnt_reg   <= '0;
                     bus_req   <= 1'b1;
                     bus_we    <= core_we;
                     bus_addr  <= {core_addr[31:2], 2'b00};
                     bus_be    <= req_be;
                     bus_wdata <= core_we ? lane_wdata : '0;
                  end
               end
            end
            REQ: begin
               // A grant arriving on the last allowed cycle still wins.
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  if (we_reg) begin
                     state_reg <= DONE;
                     core_done <= 1'b1;
                  end else begin
                     state_reg <= WAIT;
                     cnt_reg   <= '0;
                  end
               end else if (cnt_reg == CNT_LAST) begin
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  state_reg <= DONE;
                  core_done <= 1'b1;
                  core_err  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            WAIT: begin
               if (bus_rvalid) begin
                  core_rd   <= aligned_rd;
                  state_reg <= DONE;
                  core_done <= 1'b1;
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= DONE;
                  core_done <= 1'b1;
                  core_err  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios plus randomized load/store traffic
// against a byte-level reference model of lanes, alignment and timing.
module tb_dmem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_valid = 1'b0;
   logic        core_we = 1'b0;
   logic [2:0]  core_funct3 = 3'b000;
   logic [31:0] core_addr = '0;
   logic [31:0] core_wd = '0;
   logic        core_ready, core_done, core_err;
   logic [31:0] core_rd;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_gnt = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;

   int          checks = 0;
   int          passes = 0;
   int          txn_no = 0;
   logic [31:0] model_rd = '0;

   typedef struct {
      int          done_cyc;
      logic        err;
      logic [31:0] rd;
      bit          saw_req;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      bit          unstable;
      logic        req_at_done;
      logic        done_next;
   } obs_t;

   typedef struct {
      bit          illegal;
      logic        err;
      int          done_cyc;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rd;
   } exp_t;

   always #5 clk = ~clk;

   dmem_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_valid(core_valid), .core_we(core_we), .core_funct3(core_funct3),
      .core_addr(core_addr), .core_wd(core_wd),
      .core_ready(core_ready), .core_done(core_done), .core_err(core_err), .core_rd(core_rd),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   // Reference: access of nb bytes at offset off; cycle counts from the accept edge.
   function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  input int gdly, input int rdly, input logic [31:0] prev_rd);
      exp_t        e;
      int          nb;
      int          off;
      logic [31:0] mask;
      e = '{default: 0};
      nb = 1 << f3[1:0];
      off = int'(addr[1:0]);
      e.illegal = (nb == 8) || (off % nb != 0) || (we && f3[2]);
      e.be = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = we ? wd[8*(i % nb) +: 8] : 8'h00;
      mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
      e.rd = (rdata >> (8*off)) & mask;
      if (!f3[2] && nb < 4 && e.rd[8*nb-1]) e.rd = e.rd | ~mask;
      if (e.illegal) begin
         e.err = 1'b1; e.done_cyc = 1;
      end else if (gdly >= TO) begin
         e.err = 1'b1; e.done_cyc = TO + 1;
      end else if (we) begin
         e.err = 1'b0; e.done_cyc = gdly + 2;
      end else begin
         e.err = (rdly >= TO); e.done_cyc = gdly + ((rdly >= TO) ? TO - 1 : rdly) + 3;
      end
      if (e.err || we) e.rd = prev_rd;
      return e;
   endfunction

   // Drives one request and plays the bus side: gnt after gdly REQ cycles,
   // rvalid after rdly WAIT cycles, random rvalid noise while requesting.
   task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int gdly, input int rdly, output obs_t o);
      int req_k;
      int w;
      int cyc;
      bit granted;
      o = '{default: 0};
      o.done_cyc = -1;
      req_k = 0; w = 0; granted = 0;
      @(negedge clk);
      for (int i = 0; i < 20 && !core_ready; i++) @(negedge clk);
      core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wd = wd;
      bus_rdata = rdata; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      cyc = 1;
      while (cyc < 60) begin
         if (core_done) begin
            o.done_cyc = cyc; o.err = core_err; o.rd = core_rd; o.req_at_done = bus_req;
            break;
         end
         bus_gnt = 1'b0; bus_rvalid = 1'b0;
         if (bus_req) begin
            if (!o.saw_req) begin
               o.saw_req = 1; o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata; o.we = bus_we;
            end else if (bus_addr !== o.addr || bus_be !== o.be || bus_wdata !== o.wdata || bus_we !== o.we) begin
               o.unstable = 1;
            end
            bus_gnt = (req_k == gdly);
            if (bus_gnt) granted = 1;
            req_k++;
            bus_rvalid = 1'($urandom_range(0, 1));
         end else if (granted) begin
            bus_rvalid = (w == rdly);
            w++;
         end
         @(negedge clk);
         cyc++;
      end
      core_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
      @(negedge clk);
      o.done_next = core_done;
      txn_no++;
      $display("txn %0d we=%0b f3=%03b addr=%08h gdly=%0d rdly=%0d done@%0d err=%0b rd=%08h",
               txn_no, we, f3, addr, gdly, rdly, o.done_cyc, o.err, o.rd);
   endtask

   task automatic test_reset_state();
      repeat (3) @(negedge clk);
      checks++; if ({bus_req, bus_we, core_done, core_err} !== 4'b0000) $display("FAIL rst_flags: got %b expected 0000", {bus_req, bus_we, core_done, core_err}); else passes++;
      checks++; if (bus_be !== 4'h0) $display("FAIL rst_be: got %b expected 0000", bus_be); else passes++;
      checks++; if ({bus_addr, bus_wdata, core_rd} !== 96'h0) $display("FAIL rst_data: got %h expected 0", {bus_addr, bus_wdata, core_rd}); else passes++;
      checks++; if (core_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", core_ready); else passes++;
      rst_n = 1'b1;
   endtask

   task automatic test_store_sb();
      obs_t o;
      exp_t e;
      e = model(1'b1, 3'b000, 32'h1003, 32'hA5, 32'h0, 0, 0, model_rd);
      run_txn(1'b1, 3'b000, 32'h1003, 32'hA5, 32'h0, 0, 0, o);
      checks++; if (o.addr !== 32'h1000) $display("FAIL sb_addr: got %h expected 00001000", o.addr); else passes++;
      checks++; if (o.be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", o.be); else passes++;
      checks++; if (o.wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", o.wdata); else passes++;
      checks++; if (o.we !== 1'b1) $display("FAIL sb_we: got %b expected 1", o.we); else passes++;
      checks++; if (o.done_cyc !== 2 || o.err !== 1'b0) $display("FAIL sb_done: got cyc %0d err %b expected cyc 2 err 0", o.done_cyc, o.err); else passes++;
      checks++; if (o.done_next !== 1'b0) $display("FAIL sb_pulse: got %b expected 0", o.done_next); else passes++;
      model_rd = e.rd;
   endtask

   task automatic test_load_lh();
      obs_t o;
      exp_t e;
      e = model(1'b0, 3'b001, 32'h2002, 32'h0, 32'h8001_1234, 3, 2, model_rd);
      run_txn(1'b0, 3'b001, 32'h2002, 32'hFFFF_FFFF, 32'h8001_1234, 3, 2, o);
      checks++; if (o.be !== 4'b1100) $display("FAIL lh_be: got %b expected 1100", o.be); else passes++;
      checks++; if (o.we !== 1'b0 || o.wdata !== 32'h0) $display("FAIL lh_wdata: got we %b wdata %h expected 0 0", o.we, o.wdata); else passes++;
      checks++; if (o.rd !== 32'hFFFF8001) $display("FAIL lh_rd: got %h expected ffff8001", o.rd); else passes++;
      checks++; if (o.done_cyc !== 8 || o.err !== 1'b0) $display("FAIL lh_done: got cyc %0d err %b expected cyc 8 err 0", o.done_cyc, o.err); else passes++;
      model_rd = e.rd;
   endtask

   task automatic test_load_bytes();
      obs_t o;
      exp_t e;
      e = model(1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_F000, 0, 0, model_rd);
      run_txn(1'b0, 3'b100, 32'h2001, 32'h0, 32'h0000_F000, 0, 0, o);
      checks++; if (o.rd !== 32'h000000F0) $display("FAIL lbu_rd: got %h expected 000000f0", o.rd); else passes++;
      checks++; if (o.done_cyc !== 3) $display("FAIL lbu_latency: got %0d expected 3", o.done_cyc); else passes++;
      model_rd = e.rd;
      e = model(1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_F000, 1, 1, model_rd);
      run_txn(1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000_F000, 1, 1, o);
      checks++; if (o.rd !== 32'hFFFFFFF0) $display("FAIL lb_rd: got %h expected fffffff0", o.rd); else passes++;
      checks++; if (o.be !== 4'b0010) $display("FAIL lb_be: got %b expected 0010", o.be); else passes++;
      model_rd = e.rd;
   endtask

   task automatic test_misaligned();
      obs_t        o;
      logic [31:0] prev;
      prev = model_rd;
      run_txn(1'b0, 3'b010, 32'h3002, 32'h0, 32'hDEAD_BEEF, 0, 0, o);
      checks++; if (o.saw_req !== 1'b0) $display("FAIL lw_mis_noreq: got %b expected 0", o.saw_req); else passes++;
      checks++; if (o.done_cyc !== 1 || o.err !== 1'b1) $display("FAIL lw_mis_done: got cyc %0d err %b expected cyc 1 err 1", o.done_cyc, o.err); else passes++;
      checks++; if (o.rd !== prev) $display("FAIL lw_mis_rd: got %h expected %h", o.rd, prev); else passes++;
   endtask

   task automatic test_timeout();
      obs_t        o;
      logic [31:0] prev;
      prev = model_rd;
      run_txn(1'b0, 3'b010, 32'h4000, 32'h0, 32'h1234_5678, 1000, 0, o);
      checks++; if (o.done_cyc !== TO + 1 || o.err !== 1'b1) $display("FAIL to_req: got cyc %0d err %b expected cyc %0d err 1", o.done_cyc, o.err, TO + 1); else passes++;
      checks++; if (o.req_at_done !== 1'b0) $display("FAIL to_reqdrop: got %b expected 0", o.req_at_done); else passes++;
      checks++; if (o.rd !== prev) $display("FAIL to_rd: got %h expected %h", o.rd, prev); else passes++;
      run_txn(1'b0, 3'b010, 32'h4000, 32'h0, 32'h1234_5678, TO - 1, 1, o);
      checks++; if (o.done_cyc !== TO + 3 || o.err !== 1'b0) $display("FAIL to_lastgnt: got cyc %0d err %b expected cyc %0d err 0", o.done_cyc, o.err, TO + 3); else passes++;
      checks++; if (o.rd !== 32'h1234_5678) $display("FAIL to_lastgnt_rd: got %h expected 12345678", o.rd); else passes++;
      run_txn(1'b0, 3'b010, 32'h4000, 32'h0, 32'h0BAD_F00D, 0, 1000, o);
      checks++; if (o.done_cyc !== TO + 2 || o.err !== 1'b1) $display("FAIL to_wait: got cyc %0d err %b expected cyc %0d err 1", o.done_cyc, o.err, TO + 2); else passes++;
      model_rd = 32'h1234_5678;
   endtask

   task automatic test_reset_midflight();
      obs_t        o;
      logic [31:0] wd;
      @(negedge clk);
      core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h5000;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus_req !== 1'b1) $display("FAIL rstm_req_pre: got %b expected 1", bus_req); else passes++;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus_req !== 1'b0 || core_ready !== 1'b1) $display("FAIL rstm_req_drop: got req %b ready %b expected 0 1", bus_req, core_ready); else passes++;
      core_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      core_valid = 1'b1; core_addr = 32'h5004; bus_rdata = 32'hCAFE_0001;
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      checks++; if (bus_req !== 1'b0 || core_ready !== 1'b0) $display("FAIL rstm_wait_pre: got req %b ready %b expected 0 0", bus_req, core_ready); else passes++;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (core_done !== 1'b0 || core_ready !== 1'b1 || core_rd !== 32'h0) $display("FAIL rstm_wait: got done %b ready %b rd %h expected 0 1 0", core_done, core_ready, core_rd); else passes++;
      core_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_rd = '0;
      @(negedge clk);
      checks++; if (core_done !== 1'b0) $display("FAIL rstm_nodone: got %b expected 0", core_done); else passes++;
      wd = $urandom;
      run_txn(1'b1, 3'b010, 32'h10, wd, 32'h0, 0, 0, o);
      checks++; if (o.be !== 4'b1111 || o.addr !== 32'h10 || o.wdata !== wd) $display("FAIL rstm_sw_bus: got be %b addr %h wdata %h expected 1111 00000010 %h", o.be, o.addr, o.wdata, wd); else passes++;
      checks++; if (o.done_cyc !== 2 || o.err !== 1'b0) $display("FAIL rstm_sw_done: got cyc %0d err %b expected cyc 2 err 0", o.done_cyc, o.err); else passes++;
   endtask

   task automatic test_random(input int n);
      obs_t        o;
      exp_t        e;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rdata;
      int          gdly, rdly;
      for (int k = 0; k < n; k++) begin
         we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
         addr = $urandom; wd = $urandom; rdata = $urandom;
         gdly = $urandom_range(0, TO); rdly = $urandom_range(0, TO);
         e = model(we, f3, addr, wd, rdata, gdly, rdly, model_rd);
         run_txn(we, f3, addr, wd, rdata, gdly, rdly, o);
         checks++; if (o.done_cyc !== e.done_cyc) $display("FAIL rnd_done_cyc: got %0d expected %0d", o.done_cyc, e.done_cyc); else passes++;
         checks++; if (o.err !== e.err) $display("FAIL rnd_err: got %b expected %b", o.err, e.err); else passes++;
         checks++; if (o.rd !== e.rd) $display("FAIL rnd_rd: got %h expected %h", o.rd, e.rd); else passes++;
         checks++; if (o.saw_req !== !e.illegal) $display("FAIL rnd_busreq: got %b expected %b", o.saw_req, !e.illegal); else passes++;
         if (o.saw_req) begin
            checks++; if (o.be !== e.be) $display("FAIL rnd_be: got %b expected %b", o.be, e.be); else passes++;
            checks++; if (o.wdata !== e.wdata) $display("FAIL rnd_wdata: got %h expected %h", o.wdata, e.wdata); else passes++;
            checks++; if (o.addr !== (addr & 32'hFFFF_FFFC) || o.we !== we) $display("FAIL rnd_addr_we: got %h %b expected %h %b", o.addr, o.we, addr & 32'hFFFF_FFFC, we); else passes++;
            checks++; if (o.unstable !== 1'b0) $display("FAIL rnd_stable: got %b expected 0", o.unstable); else passes++;
         end
         checks++; if (o.done_next !== 1'b0 || o.req_at_done !== 1'b0) $display("FAIL rnd_pulse: got next %b req %b expected 0 0", o.done_next, o.req_at_done); else passes++;
         model_rd = e.rd;
      end
   endtask

   initial begin
      test_reset_state();
      test_store_sb();
      test_load_lh();
      test_load_bytes();
      test_misaligned();
      test_timeout();
      test_random(150);
      test_reset_midflight();
      test_random(30);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
